// File: rtl/i2c_target_responder.sv
// i2c_target_responder: I2C target endpoint serving register-pointer writes, data writes and data reads
// Ports:
//   iclk50    system clock, all logic on its rising edge
//   irst_n    asynchronous active-low reset
//   iscl/isda raw asynchronous bus inputs
//   osda_oe   1 = pull SDA low (open-drain), 0 = release
//   oreg_addr current register pointer
//   owr_stb   one-cycle pulse, owr_data valid for oreg_addr
//   owr_data  received write byte
//   ord_stb   one-cycle pulse requesting the byte at oreg_addr
//   ird_data  read byte, sampled one cycle after ord_stb
//   obusy     high from an address-matched START until STOP
// Build option: define I2C_TGT_GLITCH_FILTER_EN to insert a 3-sample majority filter after each synchronizer.
module i2c_target_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         SDA_HOLD = 4
) (
    input  logic       iclk50,
    input  logic       irst_n,
    input  logic       iscl,
    input  logic       isda,
    output logic       osda_oe,
    output logic [7:0] oreg_addr,
    output logic       owr_stb,
    output logic [7:0] owr_data,
    output logic       ord_stb,
    input  logic [7:0] ird_data,
    output logic       obusy
);
    localparam int HW = $clog2(SDA_HOLD + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_s, sda_s, scl_prev_q, sda_prev_q;
    logic       scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge iclk50 or negedge irst_n) begin
        if (!irst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], iscl};
            sda_sync_q <= {sda_sync_q[0], isda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    // Majority of the last three synchronized samples rejects single-cycle pulses.
    logic [2:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;
    always_ff @(posedge iclk50 or negedge irst_n) begin
        if (!irst_n) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
            scl_filt_q <= (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) | (scl_hist_q[1] & scl_hist_q[2]);
            sda_filt_q <= (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) | (sda_hist_q[1] & sda_hist_q[2]);
        end
    end
    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [6:0]      sh_q, sh_d;
    logic            ph_q, ph_d;
    logic            rw_q, rw_d;
    logic            ackm_q, ackm_d;
    logic            rep_q, rep_d;
    logic            busy_q, busy_d;
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            wr_stb_q, wr_stb_d;
    logic            rd_stb_q, rd_stb_d;
    logic            rd_cap_q;
    logic [HW-1:0]   hold_q, hold_d;
    logic            pend_q, pend_d;
    logic            oe_q, oe_d;
    logic [7:0]      byte_w;

    assign byte_w = {sh_q, sda_s};

    always_ff @(posedge iclk50 or negedge irst_n) begin
        if (!irst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            ph_q       <= 1'b0;
            rw_q       <= 1'b0;
            ackm_q     <= 1'b1;
            rep_q      <= 1'b0;
            busy_q     <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            rd_cap_q   <= 1'b0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            ph_q       <= ph_d;
            rw_q       <= rw_d;
            ackm_q     <= ackm_d;
            rep_q      <= rep_d;
            busy_q     <= busy_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_stb_q   <= wr_stb_d;
            rd_stb_q   <= rd_stb_d;
            rd_cap_q   <= rd_stb_q;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            oe_q       <= oe_d;
        end
    end

    // pend_q holds the SDA drive chosen at an SCL fall; it reaches the pin once hold_q runs out.
    // ph_q marks the second half of an ACK slot, or the final bit in RD_DATA.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        ph_d       = ph_q;
        rw_d       = rw_q;
        ackm_d     = ackm_q;
        rep_d      = rep_q;
        busy_d     = busy_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_stb_d   = 1'b0;
        rd_stb_d   = 1'b0;
        hold_d     = hold_q;
        pend_d     = pend_q;
        oe_d       = oe_q;
        if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
            oe_d   = (hold_q == HW'(1)) ? pend_q : oe_q;
        end
        if (start_det) begin
            state_d = ADDR;
            cnt_d   = '0;
            rep_d   = busy_q;
            hold_d  = '0;
            pend_d  = 1'b0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            rep_d   = 1'b0;
            hold_d  = '0;
            pend_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            if (scl_fall && state_q != IDLE && state_q != IGNORE)
                hold_d = HW'(SDA_HOLD);
            unique case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        sh_d  = byte_w[6:0];
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            // General call (address 0) is never acknowledged.
                            if (byte_w[7:1] == DEV_ADDR && byte_w[7:1] != 7'd0) begin
                                state_d = ADDR_ACK;
                                ph_d    = 1'b0;
                                rw_d    = byte_w[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_rise)
                        ph_d = 1'b1;
                    if (scl_fall) begin
                        if (!ph_q) begin
                            pend_d = 1'b1;
                        end else begin
                            pend_d = 1'b0;
                            ph_d   = 1'b0;
                            cnt_d  = '0;
                            if (state_q == ADDR_ACK) begin
                                state_d  = rw_q ? RD_DATA : (rep_q ? WR_DATA : REG_PTR);
                                rd_stb_d = rw_q;
                            end else begin
                                state_d    = WR_DATA;
                                reg_addr_d = (state_q == WR_ACK) ? reg_addr_q + 8'd1 : reg_addr_q;
                            end
                        end
                    end
                end
                REG_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        sh_d  = byte_w[6:0];
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ph_d = 1'b0;
                            if (state_q == REG_PTR) begin
                                reg_addr_d = byte_w;
                                state_d    = PTR_ACK;
                            end else begin
                                wr_data_d = byte_w;
                                wr_stb_d  = 1'b1;
                                state_d   = WR_ACK;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (rd_cap_q) begin
                        sh_d   = ird_data[6:0];
                        pend_d = ~ird_data[7];
                    end
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        ph_d  = (cnt_q == 3'd7) ? 1'b1 : ph_q;
                    end
                    if (scl_fall) begin
                        if (ph_q) begin
                            state_d = RD_ACK;
                            pend_d  = 1'b0;
                            ph_d    = 1'b0;
                        end else begin
                            sh_d   = {sh_q[5:0], 1'b0};
                            pend_d = ~sh_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ackm_d = sda_s;
                        ph_d   = 1'b1;
                    end
                    if (scl_fall && ph_q) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        pend_d     = 1'b0;
                        ph_d       = 1'b0;
                        cnt_d      = '0;
                        state_d    = ackm_q ? IGNORE : RD_DATA;
                        rd_stb_d   = ~ackm_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign osda_oe   = oe_q;
    assign oreg_addr = reg_addr_q;
    assign owr_stb   = wr_stb_q;
    assign owr_data  = wr_data_q;
    assign ord_stb   = rd_stb_q;
    assign obusy     = busy_q;
endmodule

// File: doc/i2c_target_responder.md
# i2c_target_responder

I2C target (slave) endpoint that answers a bus master such as the I2C clock/byte engines that drive the MPU9250 link. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It matches a 7-bit device address, then services register-pointer writes, data writes and data reads through a simple strobe-based register port. Its main uses are on-chip loopback of the master path and acting as a sensor stand-in during bring-up.

## Interface
- `DEV_ADDR`, 7'h68: 7-bit target address answered.
- `SDA_HOLD`, 4: system-clock cycles between detected SCL fall and any SDA drive change (hold time).
- `iclk50` in 1: system clock; all logic on rising edge.
- `irst_n` in 1: reset, asynchronous and active-low.
- `iscl` in 1: bus SCL, asynchronous.
- `isda` in 1: bus SDA input, asynchronous.
- `osda_oe` out 1: 1 = pull SDA low (open-drain); 0 = release.
- `oreg_addr` out 8: current register pointer.
- `owr_stb` out 1: one-cycle pulse; `owr_data` is valid for `oreg_addr`.
- `owr_data` out 8: received write byte.
- `ord_stb` out 1: one-cycle pulse requesting the byte at `oreg_addr`.
- `ird_data` in 8: read byte; sampled exactly 1 cycle after `ord_stb`.
- `obusy` out 1: high from an address-matched START until STOP.

## Operation
- Input path: 2-flop synchronizer per line, then edge detect on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are honoured in every state and take priority over bit sampling in the same cycle.
- Data bits are sampled on the detected SCL rise, MSB first. A 3-bit counter counts bits. On the 8th bit the byte completes.
- The ACK/data drive changes `SDA_HOLD` cycles after the detected SCL fall.
- States:
  - IDLE: waits for START; ignores everything else.
  - ADDR: shifts in address plus R/W bit. On a match, go to ADDR_ACK. On a mismatch, go to IGNORE with SDA released.
  - ADDR_ACK: drives SDA low for one SCL period. Next state is RD_DATA if R/W=1; otherwise REG_PTR for the first write phase after START, or WR_DATA after a repeated START write.
  - REG_PTR: the received byte loads `oreg_addr`. Go to PTR_ACK.
  - PTR_ACK: ACK, then go to WR_DATA.
  - WR_DATA: the byte is presented on `owr_data`. `owr_stb` pulses 1 cycle after the 8th SCL rise. Go to WR_ACK.
  - WR_ACK: ACK. `oreg_addr` increments at the ACK SCL fall. Return to WR_DATA.
  - RD_DATA:
    - `ord_stb` pulses on entry.
    - `ird_data` is captured into the shift register.
    - Each bit is driven after its SCL fall plus `SDA_HOLD`; `osda_oe` = ~bit.
    - After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: samples the master's ACK. ACK(0) → increment `oreg_addr` and return to RD_DATA. NACK(1) → IGNORE.
  - IGNORE: SDA released; waits for START/STOP.
- Pointer arithmetic is 8-bit and wraps 8'hFF→8'h00.
- Boundary cases:
  - Repeated START mid-byte: discard the partial byte; no strobe.
  - STOP: → IDLE, `obusy`=0, SDA released.
  - General call (address 0) is not acknowledged.
  - Reset mid-transfer: all state returns to IDLE immediately and SDA is released asynchronously.

## Timing
- Reset values: `osda_oe`=0, `owr_stb`=0, `ord_stb`=0, `owr_data`=0, `oreg_addr`=0, `obusy`=0.
- Bus-edge detection latency is 3 `iclk50` cycles from a pin change (2 sync + 1 edge reg). It is 5 cycles with the filter enabled.
- `osda_oe` changes at detected SCL fall + `SDA_HOLD` cycles. The first read bit is driven at ADDR_ACK/RD_ACK fall + `SDA_HOLD`.
- `ord_stb` to capture: 1 cycle. The external source must be combinational or 1-cycle registered.
- Minimum SCL high/low: `SDA_HOLD`+4 cycles. At 50 MHz with 400 kHz SCL (62 cycles per half), this is satisfied.

## Configuration
- `I2C_TGT_GLITCH_FILTER_EN` defined: a 3-sample majority filter is inserted after each synchronizer. Pulses of ≤1 cycle are rejected, and all detection latencies grow by 2 cycles.
- Not defined: synchronizer only. A 1-cycle SDA glitch while SCL is high may register as START/STOP.

## Test plan
- Write burst: START, 0xD0, 0x10, 0xAA, 0x55, STOP → ACK on all 4 bytes; `owr_stb` fires with (0x10,0xAA) then (0x11,0x55); `obusy` is 0 after STOP.
- Read with repeated START: START, 0xD0, 0x3B, rSTART, 0xD1, read 2 bytes, ACK then NACK, STOP, with `ird_data`=0x3B+addr → SDA returns 0x76 then 0x77; 2 `ord_stb` pulses; final `oreg_addr`=0x3D.
- Address mismatch: START, 0xA0, 0x00, STOP → `osda_oe` is never asserted; no strobes; `obusy` stays 0.
- Pointer wrap: pointer 0xFF, write 0x01, 0x02 → strobes at 0xFF then 0x00.
- Abort cases:
  - STOP after 4 bits of a data byte → no `owr_stb`; state returns to IDLE.
  - `irst_n` low during RD_DATA → `osda_oe`=0 within the same cycle.
- Glitch (macro defined): 1-cycle SDA low pulse while SCL is high → no START detected, `obusy` stays 0. With the macro undefined, a START is detected.
